// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types and constants for the 11-bit serial frame link
package serial_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HI
   } rx_state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;
   localparam logic PARITY_ODD = 1'b1;

   // Total wire bits per frame: start + payload + parity + stop.
   function automatic int frame_bits(input int data_bits);
      return data_bits + 3;
   endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - per-bit clock counter with half/full period ticks
module rx_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic half_tick,
   output logic full_tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   logic [CW-1:0] cnt;

   // Holds at the terminal count instead of wrapping; only clear restarts it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (!full_tick) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign half_tick = (cnt == CW'(CLKS_PER_BIT/2 - 1));
   assign full_tick = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver: start detect, MSB-first payload, odd parity, stop
module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sin,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int BW = $clog2(DATA_BITS + 1);

   rx_state_t state, next_state;

   logic                 sync_meta, sync_sin;
   logic                 timer_clear, half_tick, full_tick;
   logic                 start_ok, data_shift, parity_take, stop_good, stop_bad;
   logic [DATA_BITS-1:0] shreg;
   logic [BW-1:0]        bit_cnt;
   logic                 par_acc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_meta <= IDLE_LEVEL;
         sync_sin  <= IDLE_LEVEL;
      end else begin
         sync_meta <= sin;
         sync_sin  <= sync_meta;
      end
   end

   rx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear     (timer_clear),
      .half_tick (half_tick),
      .full_tick (full_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (sync_sin == START_BIT) next_state = START;
         START:   if (half_tick) next_state = (sync_sin == START_BIT) ? DATA : IDLE;
         DATA:    if (full_tick && bit_cnt == BW'(DATA_BITS - 1)) next_state = PARITY;
         PARITY:  if (full_tick) next_state = STOP;
         // Leaving STOP mid-bit lets a start bit right after the stop bit be caught.
         STOP:    if (full_tick) next_state = (sync_sin == STOP_BIT) ? IDLE : WAIT_HI;
         WAIT_HI: if (sync_sin == IDLE_LEVEL) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != IDLE);
      timer_clear = 1'b0;
      start_ok    = 1'b0;
      data_shift  = 1'b0;
      parity_take = 1'b0;
      stop_good   = 1'b0;
      stop_bad    = 1'b0;
      case (state)
         IDLE:    timer_clear = 1'b1;
         START:   if (half_tick) begin
                     timer_clear = 1'b1;
                     start_ok    = (sync_sin == START_BIT);
                  end
         DATA:    if (full_tick) begin
                     timer_clear = 1'b1;
                     data_shift  = 1'b1;
                  end
         PARITY:  if (full_tick) begin
                     timer_clear = 1'b1;
                     parity_take = 1'b1;
                  end
         STOP:    if (full_tick) begin
                     timer_clear = 1'b1;
                     stop_good   = (sync_sin == STOP_BIT);
                     stop_bad    = (sync_sin != STOP_BIT);
                  end
         WAIT_HI: timer_clear = 1'b1;
         default: timer_clear = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         par_acc    <= 1'b0;
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         valid      <= stop_good;
         parity_err <= stop_good && (par_acc != PARITY_ODD);
         frame_err  <= stop_bad;
         if (start_ok) begin
            bit_cnt <= '0;
            par_acc <= 1'b0;
         end
         if (data_shift) begin
            shreg   <= {shreg[DATA_BITS-2:0], sync_sin};
            bit_cnt <= bit_cnt + 1'b1;
            par_acc <= par_acc ^ sync_sin;
         end
         if (parity_take) begin
            par_acc <= par_acc ^ sync_sin;
         end
         // A bad-parity frame still updates data; only a bad stop bit leaves it alone.
         if (stop_good) begin
            data <= shreg;
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed self-checking bench for serial_frame_rx
module tb_serial_frame_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       sin;
   logic [7:0] data;
   logic       valid, parity_err, frame_err, busy;

   int n_checks = 0;
   int n_fail   = 0;

   int         n_valid   = 0;
   int         n_perr_v  = 0;
   int         n_perr_lo = 0;
   int         n_ferr    = 0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] prev_data = 8'h00;

   serial_frame_rx #(
      .DATA_BITS    (8),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sin        (sin),
      .data       (data),
      .valid      (valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid) begin
         n_valid   = n_valid + 1;
         prev_data = last_data;
         last_data = data;
         if (parity_err) n_perr_v = n_perr_v + 1;
      end
      if (parity_err && !valid) n_perr_lo = n_perr_lo + 1;
      if (frame_err) n_ferr = n_ferr + 1;
   end

   task automatic send_bit(input logic b);
      sin = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      send_bit(1'b0);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      send_bit(p);
      send_bit(s);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      sin   = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected %h", data, 8'h00); end
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
      n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_good_frame;
      int v0, pe0, fe0;
      v0 = n_valid; pe0 = n_perr_v + n_perr_lo; fe0 = n_ferr;
      send_frame(8'hA5, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      n_checks++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL good_valid_count: got %0d expected 1", n_valid - v0); end
      n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL good_data: got %h expected %h", data, 8'hA5); end
      n_checks++; if (n_perr_v + n_perr_lo - pe0 !== 0) begin n_fail++; $display("FAIL good_perr: got %0d expected 0", n_perr_v + n_perr_lo - pe0); end
      n_checks++; if (n_ferr - fe0 !== 0) begin n_fail++; $display("FAIL good_ferr: got %0d expected 0", n_ferr - fe0); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy: got %b expected 0", busy); end
   endtask

   task automatic test_parity_error;
      int v0, pv0, pl0;
      v0 = n_valid; pv0 = n_perr_v; pl0 = n_perr_lo;
      send_frame(8'h3C, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      n_checks++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL perr_valid_count: got %0d expected 1", n_valid - v0); end
      n_checks++; if (n_perr_v - pv0 !== 1) begin n_fail++; $display("FAIL perr_with_valid: got %0d expected 1", n_perr_v - pv0); end
      n_checks++; if (n_perr_lo - pl0 !== 0) begin n_fail++; $display("FAIL perr_alone: got %0d expected 0", n_perr_lo - pl0); end
      n_checks++; if (data !== 8'h3C) begin n_fail++; $display("FAIL perr_data: got %h expected %h", data, 8'h3C); end
   endtask

   task automatic test_frame_error;
      int v0, fe0;
      v0 = n_valid; fe0 = n_ferr;
      send_bit(1'b0);
      for (int i = 7; i >= 0; i--) send_bit(((8'h81 >> i) & 8'h01) != 0);
      send_bit(1'b1);
      sin = 1'b0;
      repeat (CPB + 40) @(negedge clk);
      n_checks++; if (n_ferr - fe0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - fe0); end
      n_checks++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d expected 0", n_valid - v0); end
      n_checks++; if (data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data_kept: got %h expected %h", data, 8'h3C); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_low_line: got %b expected 1", busy); end
      sin = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_released: got %b expected 0", busy); end
   endtask

   task automatic test_glitch;
      int v0, pe0, fe0;
      v0 = n_valid; pe0 = n_perr_v + n_perr_lo; fe0 = n_ferr;
      sin = 1'b0;
      repeat (3) @(negedge clk);
      sin = 1'b1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b expected 1", busy); end
      repeat (12) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall: got %b expected 0", busy); end
      repeat (CPB * 2) @(negedge clk);
      n_checks++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected 0", n_valid - v0); end
      n_checks++; if ((n_perr_v + n_perr_lo - pe0) + (n_ferr - fe0) !== 0) begin n_fail++; $display("FAIL glitch_err: got %0d expected 0", (n_perr_v + n_perr_lo - pe0) + (n_ferr - fe0)); end
   endtask

   task automatic test_back_to_back;
      int v0, pe0;
      v0 = n_valid; pe0 = n_perr_v + n_perr_lo;
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      n_checks++; if (n_valid - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 2", n_valid - v0); end
      n_checks++; if (prev_data !== 8'h00) begin n_fail++; $display("FAIL b2b_first_data: got %h expected %h", prev_data, 8'h00); end
      n_checks++; if (last_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_second_data: got %h expected %h", last_data, 8'hFF); end
      n_checks++; if (n_perr_v + n_perr_lo - pe0 !== 0) begin n_fail++; $display("FAIL b2b_perr: got %0d expected 0", n_perr_v + n_perr_lo - pe0); end
   endtask

   task automatic test_reset_mid_frame;
      int v0, fe0;
      v0 = n_valid; fe0 = n_ferr;
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      reset = 1'b0;
      sin   = 1'b1;
      #1;
      n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h expected %h", data, 8'h00); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
      n_checks++; if ({valid, parity_err, frame_err} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_pulses: got %b expected 000", {valid, parity_err, frame_err}); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++; if (n_valid - v0 !== 0 || n_ferr - fe0 !== 0) begin n_fail++; $display("FAIL rst_mid_discard: got %0d pulses expected 0", (n_valid - v0) + (n_ferr - fe0)); end
      send_frame(8'h12, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      n_checks++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL rst_after_valid: got %0d expected 1", n_valid - v0); end
      n_checks++; if (data !== 8'h12) begin n_fail++; $display("FAIL rst_after_data: got %h expected %h", data, 8'h12); end
   endtask

   initial begin
      reset = 1'b0;
      sin   = 1'b1;
      @(negedge clk);
      test_reset;
      test_good_frame;
      test_parity_error;
      test_frame_error;
      test_glitch;
      test_back_to_back;
      test_reset_mid_frame;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
